mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning register/result width.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports are clk and rst.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active when low.
REQ-006 valid_i  input  1  the EX/MEM latch holds an instruction.
REQ-007 wd_i  input  5  destination register address.
REQ-008 wreg_i  input  1  destination write enable.
REQ-009 wdata_i  input  DATA_W  ALU result.
REQ-010 memop_i  input  4  operation: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE.
REQ-011 mem_addr_i  input  ADDR_W  load/store byte address.
REQ-012 store_data_i  input  DATA_W  store source data.
REQ-013 mem_din_i  input  8  read byte, valid the cycle after its address is presented.
REQ-014 mem_a_o  output  ADDR_W  byte address, registered.
REQ-015 mem_dout_o  output  8  write byte, registered.
REQ-016 mem_wr_o  output  1  write strobe, registered.
REQ-017 stall_req_o  output  1  pipeline hold; high exactly when state is not IDLE.
REQ-018 valid_o  output  1  result valid, registered.
REQ-019 wd_o  output  5  destination register address, registered.
REQ-020 wreg_o  output  1  destination write enable, registered.
REQ-021 wdata_o  output  DATA_W  result, registered; also the MEM/WB forwarding source.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-023 Acceptance SHALL occur only in IDLE with valid_i=1; valid_i SHALL be ignored in ISSUE and WAIT, since upstream holds the next instruction.
REQ-024 Transfer byte count n SHALL be 1 for LB/LBU/SB, 2 for LH/LHU/SH and 4 for LW/SW.
REQ-025 NONE accepted at cycle 0 -> cycle 1: valid_o=1, with wd_o/wreg_o/wdata_o equal to the inputs; state stays IDLE.
REQ-026 Memory op accepted at cycle 0 -> latch op, address, store data and wd_i/wreg_i; register mem_a_o=addr; enter ISSUE with byte index k=0.
REQ-027 ISSUE cycles 1..n: mem_a_o = addr+k, modulo 2^ADDR_W (wraps, no alignment check); k increments each cycle.
REQ-028 Store in ISSUE: mem_wr_o=1 and mem_dout_o = store_data byte k, little-endian (byte 0 = bits 7:0).
REQ-029 mem_wr_o SHALL be 0 in every cycle that is not a store ISSUE cycle.
REQ-030 Load: mem_din_i SHALL be captured in cycles 2..n+1 into result byte k-1 (little-endian); ISSUE -> WAIT after address n-1; WAIT lasts one cycle (cycle n+1), then -> IDLE.
REQ-031 Load result: valid_o=1 at cycle n+2, wdata_o assembled, wd_o/wreg_o from the latch.
REQ-032 Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses no extension.
REQ-033 Store: ISSUE -> IDLE after byte n-1; valid_o=1 at cycle n+1 with wreg_o=0 and wdata_o=0.
REQ-034 stall_req_o SHALL be high in cycles 1..n+1 for loads and 1..n for stores; low in the acceptance cycle and in the result cycle.
REQ-035 valid_o SHALL be a single-cycle pulse per instruction.
REQ-036 When valid_o=0: wreg_o=0 and wdata_o holds its previous value.
REQ-037 A new instruction SHALL be acceptable in the same cycle valid_o pulses (back-to-back, no bubble).

Reset
REQ-038 rst=0 at a clock edge SHALL force state IDLE, k=0, and all outputs to 0 (mem_a_o, mem_dout_o, mem_wr_o, stall_req_o, valid_o, wd_o, wreg_o, wdata_o).
REQ-039 Reset mid-ISSUE or mid-WAIT SHALL abort the operation: no valid_o pulse, mem_wr_o=0 from the following cycle, and no partial result is retained.
REQ-040 The first acceptance SHALL be possible in the first cycle with rst=1.

Verification
REQ-041 LW addr 0x100, memory 0x11,0x22,0x33,0x44 -> mem_a_o 0x100..0x103 in cycles 1-4; valid_o at cycle 6 with wdata_o=0x44332211; stall_req_o high cycles 1-5.
REQ-042 LB vs LBU of byte 0x80 -> wdata_o=0xFFFFFF80 vs 0x00000080, valid_o at cycle 3; LH of 0x01,0x80 -> 0xFFFF8001.
REQ-043 SW addr 0xFFFFFFFE, data 0xA1B2C3D4 -> writes D4,C3,B2,A1 to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; valid_o at cycle 5 with wreg_o=0.
REQ-044 NONE (wd=5, wdata=0x1234) immediately followed by LW -> valid_o at cycle 1 with 0x1234; LW accepted at cycle 1 with no bubble; held valid_i ignored while stalled.
REQ-045 rst=0 at cycle 2 of an SW -> all outputs 0 at cycle 3; no valid_o pulse; next LB completes normally.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MEM pipeline stage with a byte-wide memory port.
//
// Loads and stores of 1, 2 or 4 bytes are serialised over an 8-bit memory
// port, one byte per cycle, little-endian. Non-memory instructions pass
// straight through to the MEM/WB outputs in one cycle. While a transfer is
// in flight the stage holds the pipeline through stall_req_o.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   valid_i        EX/MEM latch holds an instruction
//   wd_i/wreg_i    destination register address / write enable
//   wdata_i        ALU result (pass-through for non-memory ops)
//   memop_i        0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//   mem_addr_i     load/store byte address
//   store_data_i   store source data
//   mem_din_i      read byte, valid the cycle after its address
//   mem_a_o        byte address (registered)
//   mem_dout_o     write byte (registered)
//   mem_wr_o       write strobe (registered)
//   stall_req_o    pipeline hold, high whenever a transfer is in flight
//   valid_o        one-cycle result pulse (registered)
//   wd_o/wreg_o    destination register address / write enable (registered)
//   wdata_o        result (registered), also the MEM/WB forwarding source
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        memop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Decoded operation: direction, signedness of a load, transfer length.
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       sext;
    logic [2:0] nbytes;
  } op_t;

  state_t            state_q;
  op_t               op_q;
  op_t               dec;
  logic [2:0]        k_q;
  logic [2:0]        k_nxt;
  logic              last_byte;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       rbuf_d;
  logic [4:0]        wd_lat_q;
  logic              wreg_lat_q;
  logic              capture;
  logic [1:0]        cap_idx;
  logic [DATA_W-1:0] load_res;

  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              valid_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec = '0;
    unique case (memop_i)
      4'd1: dec = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, nbytes: 3'd1}; // LB
      4'd2: dec = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b1, nbytes: 3'd2}; // LH
      4'd3: dec = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, nbytes: 3'd4}; // LW
      4'd4: dec = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, nbytes: 3'd1}; // LBU
      4'd5: dec = '{is_load: 1'b1, is_store: 1'b0, sext: 1'b0, nbytes: 3'd2}; // LHU
      4'd6: dec = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, nbytes: 3'd1}; // SB
      4'd7: dec = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, nbytes: 3'd2}; // SH
      4'd8: dec = '{is_load: 1'b0, is_store: 1'b1, sext: 1'b0, nbytes: 3'd4}; // SW
      default: dec = '0;                                                     // NONE
    endcase
  end

  assign k_nxt     = k_q + 3'd1;
  assign last_byte = (k_nxt == op_q.nbytes);

  // Read data lags its address by one cycle: the byte arriving while k is
  // current belongs to address k-1. WAIT exists only to catch the last byte.
  assign capture = op_q.is_load && ((state_q == ISSUE && k_q != 3'd0) || state_q == WAIT);
  assign cap_idx = 2'(k_q - 3'd1);

  always_comb begin
    rbuf_d = rbuf_q;
    if (capture) rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din_i;
  end

  // Extension uses rbuf_d so the byte captured in WAIT is already included.
  always_comb begin
    load_res = '0;
    unique case (op_q.nbytes)
      3'd1:    load_res = op_q.sext ? DATA_W'($signed(rbuf_d[7:0]))
                                    : DATA_W'(rbuf_d[7:0]);
      3'd2:    load_res = op_q.sext ? DATA_W'($signed(rbuf_d[15:0]))
                                    : DATA_W'(rbuf_d[15:0]);
      default: load_res = DATA_W'(rbuf_d);
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      rbuf_q     <= '0;
      wd_lat_q   <= '0;
      wreg_lat_q <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      valid_q    <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      // Pulses default low; wdata_q and wd_q hold between results.
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      mem_wr_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (dec.is_load || dec.is_store) begin
              op_q       <= dec;
              addr_q     <= mem_addr_i;
              sdata_q    <= store_data_i[31:0];
              wd_lat_q   <= wd_i;
              wreg_lat_q <= wreg_i;
              rbuf_q     <= '0;
              k_q        <= 3'd0;
              mem_a_q    <= mem_addr_i;
              state_q    <= ISSUE;
              if (dec.is_store) begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= store_data_i[7:0];
              end
            end else begin
              valid_q <= 1'b1;
              wd_q    <= wd_i;
              wreg_q  <= wreg_i;
              wdata_q <= wdata_i;
            end
          end
        end

        ISSUE: begin
          k_q    <= k_nxt;
          rbuf_q <= rbuf_d;
          if (last_byte) begin
            if (op_q.is_load) begin
              state_q <= WAIT;
            end else begin
              state_q <= IDLE;
              k_q     <= 3'd0;
              valid_q <= 1'b1;
              wd_q    <= wd_lat_q;
              wdata_q <= '0;
            end
          end else begin
            // Address arithmetic wraps at 2^ADDR_W; no alignment check.
            mem_a_q <= addr_q + ADDR_W'(k_nxt);
            if (op_q.is_store) begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= sdata_q[{k_nxt[1:0], 3'b000} +: 8];
            end
          end
        end

        WAIT: begin
          state_q <= IDLE;
          k_q     <= 3'd0;
          rbuf_q  <= rbuf_d;
          valid_q <= 1'b1;
          wd_q    <= wd_lat_q;
          wreg_q  <= wreg_lat_q;
          wdata_q <= load_res;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a_o     = mem_a_q;
  assign mem_dout_o  = mem_dout_q;
  assign mem_wr_o    = mem_wr_q;
  assign stall_req_o = (state_q != IDLE);
  assign valid_o     = valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access.
//
// Each instruction is turned into a per-cycle expectation (address, strobe,
// stall, result) from its byte count and a byte-addressed memory image; one
// compare process checks every DUT output against those expectations on the
// falling edge of each cycle. Stall cycles are filled with random instructions
// held on valid_i, which the DUT must ignore.
// -----------------------------------------------------------------------------
module tb_mem_access;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXC = 512;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic [4:0]    wd_i;
  logic          wreg_i;
  logic [DW-1:0] wdata_i;
  logic [3:0]    memop_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] store_data_i;
  logic [7:0]    mem_din_i;
  logic [AW-1:0] mem_a_o;
  logic [7:0]    mem_dout_o;
  logic          mem_wr_o;
  logic          stall_req_o;
  logic          valid_o;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [DW-1:0] wdata_o;

  mem_access #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .memop_i     (memop_i),
    .mem_addr_i  (mem_addr_i),
    .store_data_i(store_data_i),
    .mem_din_i   (mem_din_i),
    .mem_a_o     (mem_a_o),
    .mem_dout_o  (mem_dout_o),
    .mem_wr_o    (mem_wr_o),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectations, indexed by cycle number.
  logic        exp_rstz  [MAXC];
  logic        exp_stall [MAXC];
  logic        exp_wr    [MAXC];
  logic        exp_valid [MAXC];
  logic        exp_wreg  [MAXC];
  logic        exp_chkwd [MAXC];
  logic        chk_a     [MAXC];
  logic [31:0] exp_a     [MAXC];
  logic [31:0] exp_wdata [MAXC];
  logic [7:0]  exp_dout  [MAXC];
  logic [4:0]  exp_wd    [MAXC];

  logic [7:0] bmem [logic [31:0]];
  logic [31:0] model_wdata = 32'h0;
  logic [31:0] a_last = 32'h0;
  bit done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_rstz[i]  = 1'b0; exp_stall[i] = 1'b0; exp_wr[i]    = 1'b0;
      exp_valid[i] = 1'b0; exp_wreg[i]  = 1'b0; exp_chkwd[i] = 1'b0;
      chk_a[i]     = 1'b0; exp_a[i]     = '0;   exp_wdata[i] = '0;
      exp_dout[i]  = '0;   exp_wd[i]    = '0;
    end
  endtask

  // Memory responder: the byte for the address shown in cycle c appears in c+1.
  initial begin
    mem_din_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem_din_i = rd(a_last);
      a_last    = mem_a_o;
    end
  end

  task automatic compare(input int c);
    if (exp_rstz[c]) begin
      check("rst_mem_a",    mem_a_o,     32'h0);
      check("rst_mem_dout", mem_dout_o,  32'h0);
      check("rst_mem_wr",   mem_wr_o,    32'h0);
      check("rst_stall",    stall_req_o, 32'h0);
      check("rst_valid",    valid_o,     32'h0);
      check("rst_wd",       wd_o,        32'h0);
      check("rst_wreg",     wreg_o,      32'h0);
      check("rst_wdata",    wdata_o,     32'h0);
      model_wdata = 32'h0;
    end else begin
      check("stall",  stall_req_o, exp_stall[c]);
      check("mem_wr", mem_wr_o,    exp_wr[c]);
      check("valid",  valid_o,     exp_valid[c]);
      check("wreg",   wreg_o,      exp_valid[c] ? exp_wreg[c] : 1'b0);
      if (exp_valid[c]) model_wdata = exp_wdata[c];
      if (exp_chkwd[c]) check("wd", wd_o, exp_wd[c]);
      check("wdata", wdata_o, model_wdata);
      if (chk_a[c])  check("mem_a",    mem_a_o,    exp_a[c]);
      if (exp_wr[c]) check("mem_dout", mem_dout_o, exp_dout[c]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && !done) compare(cyc);
    end
  end

  // Present one instruction in the current cycle and record what it must do.
  task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata, output int c0, output int nxt);
    int n;
    logic [31:0] w;
    @(negedge clk);
    c0 = cyc;
    rst = 1'b1; valid_i = 1'b1; memop_i = op; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; mem_addr_i = addr; store_data_i = sdata;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 1;
      OP_LH, OP_LHU, OP_SH: n = 2;
      OP_LW, OP_SW:         n = 4;
      default:              n = 0;
    endcase
    if (n == 0) begin
      exp_valid[c0+1] = 1'b1; exp_wreg[c0+1] = wreg; exp_wdata[c0+1] = wdata;
      exp_chkwd[c0+1] = 1'b1; exp_wd[c0+1]   = wd;
      nxt = c0 + 1;
    end else if (op == OP_SB || op == OP_SH || op == OP_SW) begin
      for (int j = 0; j < n; j++) begin
        chk_a[c0+1+j]     = 1'b1;
        exp_a[c0+1+j]     = addr + 32'(j);
        exp_wr[c0+1+j]    = 1'b1;
        exp_dout[c0+1+j]  = sdata[8*j +: 8];
        exp_stall[c0+1+j] = 1'b1;
      end
      exp_valid[c0+n+1] = 1'b1; exp_wreg[c0+n+1] = 1'b0; exp_wdata[c0+n+1] = 32'h0;
      nxt = c0 + n + 1;
    end else begin
      w = 32'h0;
      for (int j = 0; j < n; j++) begin
        chk_a[c0+1+j] = 1'b1;
        exp_a[c0+1+j] = addr + 32'(j);
        w = w | (32'(rd(addr + 32'(j))) << (8 * j));
      end
      for (int j = 1; j <= n + 1; j++) exp_stall[c0+j] = 1'b1;
      if (op == OP_LB) w = {{24{w[7]}}, w[7:0]};
      if (op == OP_LH) w = {{16{w[15]}}, w[15:0]};
      exp_valid[c0+n+2] = 1'b1; exp_wreg[c0+n+2] = wreg; exp_wdata[c0+n+2] = w;
      exp_chkwd[c0+n+2] = 1'b1; exp_wd[c0+n+2]   = wd;
      nxt = c0 + n + 2;
    end
  endtask

  // A random instruction held on valid_i while the stage is stalled.
  task automatic garbage();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b1; memop_i = 4'($urandom_range(0, 15));
    wd_i = 5'($urandom); wreg_i = 1'b1; wdata_i = $urandom;
    mem_addr_i = $urandom; store_data_i = $urandom;
  endtask

  task automatic run(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                     input logic [31:0] wdata, input logic [31:0] addr,
                     input logic [31:0] sdata, output int c0);
    int nxt;
    issue(op, wd, wreg, wdata, addr, sdata, c0, nxt);
    repeat (nxt - c0 - 1) garbage();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b1; valid_i = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0; valid_i = 1'b0;
      clear_from(cyc + 1);
      exp_rstz[cyc+1] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, cn;
    rst = 1'b0; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    memop_i = '0; mem_addr_i = '0; store_data_i = '0;
    clear_from(0);
    bmem[32'h100] = 8'h11; bmem[32'h101] = 8'h22;
    bmem[32'h102] = 8'h33; bmem[32'h103] = 8'h44;
    bmem[32'h200] = 8'h80;
    bmem[32'h300] = 8'h01; bmem[32'h301] = 8'h80;
    bmem[32'h500] = 8'h7F; bmem[32'h501] = 8'hFF;

    do_reset(3);

    // NONE immediately followed by LW, no bubble.
    run(OP_NONE, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, c);
    check("pin_none_valid_c1", 32'(exp_valid[c+1]), 32'h1);
    check("pin_none_wdata",    exp_wdata[c+1], 32'h1234);
    run(OP_LW, 5'd7, 1'b1, 32'h0, 32'h100, 32'h0, cn);
    check("pin_lw_issue_no_bubble", 32'(cn - c), 32'd1);
    check("pin_lw_a_c4",      exp_a[cn+4],       32'h103);
    check("pin_lw_stall_c5",  32'(exp_stall[cn+5]), 32'h1);
    check("pin_lw_stall_c6",  32'(exp_stall[cn+6]), 32'h0);
    check("pin_lw_valid_c6",  32'(exp_valid[cn+6]), 32'h1);
    check("pin_lw_wdata",     exp_wdata[cn+6],   32'h44332211);

    // Sign versus zero extension.
    run(OP_LB, 5'd1, 1'b1, 32'h0, 32'h200, 32'h0, c);
    check("pin_lb_valid_c3", 32'(exp_valid[c+3]), 32'h1);
    check("pin_lb_wdata",    exp_wdata[c+3], 32'hFFFFFF80);
    run(OP_LBU, 5'd2, 1'b1, 32'h0, 32'h200, 32'h0, c);
    check("pin_lbu_wdata",   exp_wdata[c+3], 32'h00000080);
    run(OP_LH, 5'd3, 1'b1, 32'h0, 32'h300, 32'h0, c);
    check("pin_lh_wdata",    exp_wdata[c+4], 32'hFFFF8001);
    run(OP_LHU, 5'd4, 1'b1, 32'h0, 32'h300, 32'h0, c);
    check("pin_lhu_wdata",   exp_wdata[c+4], 32'h00008001);

    // Store wrapping past the top of the address space.
    run(OP_SW, 5'd6, 1'b1, 32'h0, 32'hFFFFFFFE, 32'hA1B2C3D4, c);
    check("pin_sw_a_c3",     exp_a[c+3],        32'h0);
    check("pin_sw_dout_c4",  32'(exp_dout[c+4]), 32'hA1);
    check("pin_sw_valid_c5", 32'(exp_valid[c+5]), 32'h1);

    run(OP_SB, 5'd8, 1'b1, 32'h0, 32'h400, 32'h00000055, c);
    run(OP_SH, 5'd9, 1'b1, 32'h0, 32'h401, 32'h0000BEEF, c);
    run(4'd12, 5'd10, 1'b1, 32'hCAFE0001, 32'h0, 32'h0, c);
    run(OP_NONE, 5'd11, 1'b0, 32'h00000077, 32'h0, 32'h0, c);
    idle(3);
    run(OP_LH, 5'd12, 1'b1, 32'h0, 32'h500, 32'h0, c);
    check("pin_lh500_wdata", exp_wdata[c+4], 32'hFFFFFF7F);
    run(OP_LHU, 5'd13, 1'b1, 32'h0, 32'h500, 32'h0, c);

    // Reset in the second cycle of a store aborts it; the next load completes.
    begin
      int c0, nxt;
      issue(OP_SW, 5'd14, 1'b1, 32'h0, 32'h600, 32'h01020304, c0, nxt);
      garbage();
      do_reset(1);
      check("pin_abort_no_valid", 32'(exp_valid[c0+5]), 32'h0);
    end
    run(OP_LB, 5'd15, 1'b1, 32'h0, 32'h200, 32'h0, c);
    check("pin_lb2_wdata", exp_wdata[c+3], 32'hFFFFFF80);
    idle(4);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
